// File: rtl/mux_rr_arb.sv
// ============================================================================
// Module   : mux_rr_arb
// Brief    : N-channel registered mux with valid/ready handshakes; an internal
//            fixed-priority or round-robin arbiter picks the source channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arb #(
  parameter int NCH  = 4,
  parameter int DW   = 8,
  parameter int SW   = 2,
  parameter int MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DW-1:0]  r_data;
  logic [SW-1:0]  r_sel;
  logic           r_valid;
  logic [SW-1:0]  r_ptr;

  logic           w_load_en;
  logic           w_any;
  logic           w_xfer;
  logic [NCH-1:0] w_req_hi;
  logic [SW-1:0]  w_gnt;
  logic [SW-1:0]  w_ptr_nxt;

  function automatic logic [SW-1:0] f_lowest(input logic [NCH-1:0] v);
    f_lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SW'(i);
    end
  endfunction

  // Round-robin: requests at or above the pointer win first; if none, the
  // wrap-around search is simply the lowest requester overall.
  generate
    if (MODE == 1) begin : g_rr
      logic [NCH-1:0] w_mask;
      always_comb begin
        w_mask = '0;
        for (int i = 0; i < NCH; i++) begin
          w_mask[i] = (i >= int'(r_ptr));
        end
      end
      assign w_req_hi = in_valid & w_mask;
    end else begin : g_fp
      assign w_req_hi = '0;
    end
  endgenerate

  assign w_gnt     = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(in_valid);
  assign w_any     = |in_valid;
  assign w_load_en = ~r_valid | out_ready;
  assign w_xfer    = w_any & w_load_en & rst_n;
  assign w_ptr_nxt = (w_gnt == SW'(NCH - 1)) ? '0 : w_gnt + SW'(1);

  assign in_ready  = w_xfer ? (NCH'(1) << w_gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= in_data[w_gnt*DW +: DW];
      r_sel   <= w_gnt;
      r_valid <= 1'b1;
      if (MODE == 1) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes.
- Successor to the team's combinational 2:1 and 4:1 muxes.
- Selection is made by an internal arbiter instead of an external select:
  - MODE=0: fixed priority.
  - MODE=1: round-robin.
- Winning word plus its channel index are captured into a single output register stage.
- Sits between multiple producers and one downstream consumer, e.g. a shared bus or FIFO write port.

Parameters:
- NCH, 4, number of input channels (2..16).
- DW, 8, data width per channel in bits.
- SW, 2, index width; must equal ceil(log2(NCH)).
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NCH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; one-hot or zero.
- out_data  output  DW  registered selected data.
- out_sel  output  SW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous, any time): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready=0 while rst_n is low.
- load_en = !out_valid | out_ready. The register can accept a new word when it is empty or is being drained this same cycle.
- Grant (combinational, computed every cycle from in_valid and ptr):
  - MODE=0: g = lowest i with in_valid[i]=1.
  - MODE=1: g = first i with in_valid[i]=1 scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (mod NCH).
  - No valid input: no grant.
- in_ready[g] = load_en & any(in_valid). All other in_ready bits = 0. in_ready never asserts for a channel whose in_valid is 0.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. Next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Latency: input transfer at edge k, word visible on out_* after edge k (1 cycle).
- Drain with no new grant (out_valid & out_ready & no input transfer): out_valid <= 0. out_data/out_sel keep their old values (don't-care to consumer).
- Simultaneous drain and load: output replaced in the same edge, out_valid stays 1. Full throughput: 1 word/cycle.
- Backpressure (out_valid & !out_ready):
  - out_data, out_sel, out_valid held stable.
  - All in_ready = 0.
  - ptr unchanged.
- Round-robin pointer (MODE=1): on each transfer, ptr <= (g+1) mod NCH, wrapping from NCH-1 to 0. No transfer: ptr holds. MODE=0: ptr unused, stays 0.
- Fairness (MODE=1): with all NCH channels continuously valid and out_ready=1, grants cycle 0,1,...,NCH-1,0,... Each channel waits at most NCH-1 transfers.
- Producers may change in_data/in_valid freely while not granted. A producer that drops in_valid before being granted loses no state in the block.
- NCH not a power of two: ptr and g never exceed NCH-1. Unused index codes never appear on out_sel.
- Reset mid-transfer: the word in the register is discarded, and the arbitration restarts from ptr=0.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n=0 mid-stream with out_valid=1.
  - Response: out_valid, out_data, out_sel go to 0 immediately without a clock edge, and in_ready=0000. After release with in_valid=1111, the first grant is channel 0.
- Round-robin rotation:
  - Stimulus: MODE=1, NCH=4, DW=8; in_data = {8'h33,8'h22,8'h11,8'h00} (channel 3 is the MSB byte), in_valid=1111, out_ready=1, 6 cycles.
  - Response: out_sel sequence 0,1,2,3,0,1; out_data 00,11,22,33,00,11; out_valid=1 from the cycle after the first transfer.
- Skip idle channels:
  - Stimulus: MODE=1, ptr=1, in_valid=1001.
  - Response: grant channel 3, then ptr=0 and next grant channel 0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_sel=2 and out_data=8'h22 loaded.
  - Response: outputs held at 2/8'h22, in_ready=0000, ptr unchanged. When out_ready returns to 1, channel 3 is granted in that same cycle.
- Fixed priority:
  - Stimulus: MODE=0, in_valid=1110 held, out_ready=1.
  - Response: out_sel=1 every cycle; channels 2 and 3 are never granted.
- Drain to empty:
  - Stimulus: single word from channel 2, then in_valid=0000, out_ready=1.
  - Response: out_valid=1 for exactly one cycle, then 0; no spurious in_ready.
